// File: rtl/imm_pack.sv
// Constant packer: splits a 32-bit constant into the shortest sequence of
// (16-bit immediate, extension op) words that the immediate extender rebuilds.
module imm_pack #(
    parameter int ENABLE_SHIFT = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_last,
    output logic [CNT_W-1:0] const_count,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    localparam logic [1:0] EOP_SIGN  = 2'b00;
    localparam logic [1:0] EOP_ZERO  = 2'b01;
    localparam logic [1:0] EOP_UPPER = 2'b10;
    localparam logic [1:0] EOP_SHIFT = 2'b11;

    state_t             state_reg;
    logic [15:0]        imm_reg;
    logic [1:0]         eop_reg;
    logic               last_reg;
    logic               two_reg;
    logic [15:0]        lo_reg;
    logic [CNT_W-1:0]   const_count_reg;
    logic [CNT_W-1:0]   word_count_reg;

    logic               sign_fit;
    logic               zero_fit;
    logic               upper_fit;
    logic               shift_fit;
    logic [15:0]        cls_imm;
    logic [1:0]         cls_eop;
    logic               cls_two;
    logic               out_hs;

    assign sign_fit  = (in_value[31:15] == {17{in_value[15]}});
    assign zero_fit  = (in_value[31:16] == 16'h0000);
    assign upper_fit = (in_value[15:0] == 16'h0000);
    assign shift_fit = (ENABLE_SHIFT != 0) && (in_value[1:0] == 2'b00) &&
                       (in_value[31:17] == {15{in_value[17]}});

    // Priority order matters: 0x00001234 must come out as a sign word, not zero.
    always_comb begin
        cls_imm = in_value[31:16];
        cls_eop = EOP_UPPER;
        cls_two = 1'b1;
        if (sign_fit) begin
            cls_imm = in_value[15:0];
            cls_eop = EOP_SIGN;
            cls_two = 1'b0;
        end else if (zero_fit) begin
            cls_imm = in_value[15:0];
            cls_eop = EOP_ZERO;
            cls_two = 1'b0;
        end else if (upper_fit) begin
            cls_imm = in_value[31:16];
            cls_eop = EOP_UPPER;
            cls_two = 1'b0;
        end else if (shift_fit) begin
            cls_imm = in_value[17:2];
            cls_eop = EOP_SHIFT;
            cls_two = 1'b0;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == EMIT1) || (state_reg == EMIT2);
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            imm_reg   <= 16'h0000;
            eop_reg   <= 2'b00;
            last_reg  <= 1'b0;
            two_reg   <= 1'b0;
            lo_reg    <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        imm_reg   <= cls_imm;
                        eop_reg   <= cls_eop;
                        last_reg  <= !cls_two;
                        two_reg   <= cls_two;
                        lo_reg    <= in_value[15:0];
                        state_reg <= EMIT1;
                    end
                end
                EMIT1: begin
                    if (out_ready) begin
                        if (two_reg) begin
                            imm_reg   <= lo_reg;
                            eop_reg   <= EOP_ZERO;
                            last_reg  <= 1'b1;
                            state_reg <= EMIT2;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                EMIT2: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Counters wrap freely; no saturation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            const_count_reg <= '0;
            word_count_reg  <= '0;
        end else if (out_hs) begin
            word_count_reg <= word_count_reg + 1'b1;
            if (last_reg) begin
                const_count_reg <= const_count_reg + 1'b1;
            end
        end
    end

    assign out_imm     = imm_reg;
    assign out_eop     = eop_reg;
    assign out_last    = last_reg;
    assign const_count = const_count_reg;
    assign word_count  = word_count_reg;

endmodule

// File: tb/tb_imm_pack.sv
// Directed-vector and oracle bench for imm_pack, plus a no-shift instance
// and a narrow-counter instance for the parameter-dependent cases.
module tb_imm_pack;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic [15:0] const_count;
    logic [15:0] word_count;

    logic        ns_in_valid;
    logic        ns_in_ready;
    logic [31:0] ns_in_value;
    logic        ns_out_valid;
    logic        ns_out_ready;
    logic [15:0] ns_out_imm;
    logic [1:0]  ns_out_eop;
    logic        ns_out_last;
    logic [15:0] ns_const_count;
    logic [15:0] ns_word_count;

    logic        w4_in_ready;
    logic        w4_out_valid;
    logic [15:0] w4_out_imm;
    logic [1:0]  w4_out_eop;
    logic        w4_out_last;
    logic [3:0]  w4_const_count;
    logic [3:0]  w4_word_count;

    int checks = 0;
    int failures = 0;

    imm_pack dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_eop(out_eop), .out_last(out_last),
        .const_count(const_count), .word_count(word_count)
    );

    imm_pack #(.ENABLE_SHIFT(0)) dut_ns (
        .clk(clk), .reset_n(reset_n),
        .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_value(ns_in_value),
        .out_valid(ns_out_valid), .out_ready(ns_out_ready),
        .out_imm(ns_out_imm), .out_eop(ns_out_eop), .out_last(ns_out_last),
        .const_count(ns_const_count), .word_count(ns_word_count)
    );

    // Shares the main stimulus; only its 4-bit counters are inspected.
    imm_pack #(.CNT_W(4)) dut_w4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(w4_in_ready), .in_value(in_value),
        .out_valid(w4_out_valid), .out_ready(out_ready),
        .out_imm(w4_out_imm), .out_eop(w4_out_eop), .out_last(w4_out_last),
        .const_count(w4_const_count), .word_count(w4_word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] value;
        int          nwords;
        logic [18:0] w0;
        logic [18:0] w1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
        case (eop)
            2'b00:   extend = {{16{imm[15]}}, imm};
            2'b01:   extend = {16'h0000, imm};
            2'b10:   extend = {imm, 16'h0000};
            default: extend = {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    function automatic bit one_word_fits(input logic [31:0] v);
        logic [31:0] s;
        s = {{14{v[17]}}, v[17:2], 2'b00};
        one_word_fits = ({{16{v[15]}}, v[15:0]} == v) || (v[31:16] == 16'h0) ||
                        (v[15:0] == 16'h0) || (s == v);
    endfunction

    // Called at a negedge; returns at the negedge after the input is taken.
    task automatic send_const(input logic [31:0] v);
        int budget = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Captures the presented word and lets out_ready (assumed high) take it.
    task automatic get_word(output logic [18:0] w, output bit ok);
        int budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        ok = out_valid;
        w = {out_imm, out_eop, out_last};
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL word_timeout: out_valid got 0 expected 1");
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        vecs[13];
        logic [18:0] w;
        bit          ok;
        logic [15:0] wc0;
        logic [15:0] cc0;
        logic [31:0] v;
        logic [31:0] acc;
        int          nw;
        bit          done;
        bit          seen_beef;

        vecs[0]  = '{32'hFFFF8000, 1, {16'h8000, 2'b00, 1'b1}, 19'h0};
        vecs[1]  = '{32'h00001234, 1, {16'h1234, 2'b00, 1'b1}, 19'h0};
        vecs[2]  = '{32'h0000ABCD, 1, {16'hABCD, 2'b01, 1'b1}, 19'h0};
        vecs[3]  = '{32'h12340000, 1, {16'h1234, 2'b10, 1'b1}, 19'h0};
        vecs[4]  = '{32'h0001FFFC, 1, {16'h7FFF, 2'b11, 1'b1}, 19'h0};
        vecs[5]  = '{32'h12345678, 2, {16'h1234, 2'b10, 1'b0}, {16'h5678, 2'b01, 1'b1}};
        vecs[6]  = '{32'h00000000, 1, {16'h0000, 2'b00, 1'b1}, 19'h0};
        vecs[7]  = '{32'hFFFFFFFF, 1, {16'hFFFF, 2'b00, 1'b1}, 19'h0};
        vecs[8]  = '{32'h00008000, 1, {16'h8000, 2'b01, 1'b1}, 19'h0};
        vecs[9]  = '{32'hFFFE0000, 1, {16'hFFFE, 2'b10, 1'b1}, 19'h0};
        vecs[10] = '{32'hFFFE0004, 1, {16'h8001, 2'b11, 1'b1}, 19'h0};
        vecs[11] = '{32'h0001FFFE, 2, {16'h0001, 2'b10, 1'b0}, {16'hFFFE, 2'b01, 1'b1}};
        vecs[12] = '{32'h80000001, 2, {16'h8000, 2'b10, 1'b0}, {16'h0001, 2'b01, 1'b1}};

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_value     = 32'h0;
        out_ready    = 1'b1;
        ns_in_valid  = 1'b0;
        ns_in_value  = 32'h0;
        ns_out_ready = 1'b1;

        @(negedge clk);
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_word", {13'h0, out_imm, out_eop, out_last}, 32'h0);
        check("reset_counts", {const_count, word_count}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors with out_ready held high.
        for (int i = 0; i < 13; i++) begin
            wc0 = word_count;
            cc0 = const_count;
            send_const(vecs[i].value);
            get_word(w, ok);
            check($sformatf("vec%0d_w0", i), {13'h0, w}, {13'h0, vecs[i].w0});
            if (vecs[i].nwords == 2) begin
                check($sformatf("vec%0d_gapless", i), {31'h0, out_valid}, 32'h1);
                get_word(w, ok);
                check($sformatf("vec%0d_w1", i), {13'h0, w}, {13'h0, vecs[i].w1});
            end
            check($sformatf("vec%0d_idle_after", i), {30'h0, in_ready, out_valid}, 32'h2);
            check($sformatf("vec%0d_wc", i), {16'h0, word_count}, {16'h0, wc0 + 16'(vecs[i].nwords)});
            check($sformatf("vec%0d_cc", i), {16'h0, const_count}, {16'h0, cc0 + 16'd1});
            $display("txn vec%0d value=%08h words=%0d", i, vecs[i].value, vecs[i].nwords);
        end

        // Two words under back-pressure: each word held 3 stalled cycles.
        wc0 = word_count;
        cc0 = const_count;
        out_ready = 1'b0;
        send_const(32'h12345678);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold_w0_%0d", k), {11'h0, out_valid, in_ready, out_imm, out_eop, out_last},
                  {11'h0, 1'b1, 1'b0, 16'h1234, 2'b10, 1'b0});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold_w1_%0d", k), {11'h0, out_valid, in_ready, out_imm, out_eop, out_last},
                  {11'h0, 1'b1, 1'b0, 16'h5678, 2'b01, 1'b1});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after", {30'h0, in_ready, out_valid}, 32'h2);
        check("bp_counts", {word_count - wc0, const_count - cc0}, {16'd2, 16'd1});
        $display("txn backpressure value=12345678 words=2");

        // ENABLE_SHIFT=0 instance: shift-encodable value falls back to two words.
        check("ns_ready", {31'h0, ns_in_ready}, 32'h1);
        ns_in_valid = 1'b1;
        ns_in_value = 32'h0001FFFC;
        @(negedge clk);
        ns_in_valid = 1'b0;
        check("ns_w0", {12'h0, ns_out_valid, ns_out_imm, ns_out_eop, ns_out_last},
              {12'h0, 1'b1, 16'h0001, 2'b10, 1'b0});
        @(negedge clk);
        check("ns_w1", {12'h0, ns_out_valid, ns_out_imm, ns_out_eop, ns_out_last},
              {12'h0, 1'b1, 16'hFFFC, 2'b01, 1'b1});
        @(negedge clk);
        check("ns_done", {15'h0, ns_out_valid, ns_const_count}, {15'h0, 1'b0, 16'd1});
        check("ns_words", {16'h0, ns_word_count}, 32'd2);
        $display("txn noshift value=0001FFFC words=2");

        // Asynchronous reset while the second word is pending.
        send_const(32'hDEADBEEF);
        check("rst_w0", {13'h0, out_imm, out_eop, out_last}, {13'h0, 16'hDEAD, 2'b10, 1'b0});
        @(negedge clk);
        check("rst_in_emit2", {15'h0, out_valid, out_imm}, {15'h0, 1'b1, 16'hBEEF});
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {12'h0, out_valid, in_ready, out_imm, out_eop, out_last}, {12'h0, 2'b01, 19'h0});
        check("rst_async_counts", {const_count, word_count}, 32'h0);
        check("rst_async_w4", {24'h0, w4_const_count, w4_word_count}, 32'h0);
        #1 reset_n = 1'b1;
        seen_beef = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) seen_beef = 1'b1;
        end
        check("rst_no_beef", {31'h0, seen_beef}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        $display("txn reset_mid value=DEADBEEF");

        // Narrow counters wrap after 16 constants.
        for (int k = 0; k < 15; k++) begin
            send_const(32'(k));
            get_word(w, ok);
        end
        check("w4_at_15", {24'h0, w4_const_count, w4_word_count}, {24'h0, 4'hF, 4'hF});
        send_const(32'h7);
        get_word(w, ok);
        check("w4_wrap", {24'h0, w4_const_count, w4_word_count}, 32'h0);
        check("main_at_16", {16'h0, const_count}, 32'd16);
        $display("txn wrap constants=16");

        // Oracle: rebuild each constant through the extender and lui/ori combine.
        for (int r = 0; r < 1000; r++) begin
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = {{16{1'b0}}, 16'($urandom)} ^ ({32{$urandom_range(0, 1) == 1}} & 32'hFFFF0000);
                2: v = {16'h0000, 16'($urandom)};
                3: v = {16'($urandom), 16'h0000};
                default: begin
                    v = {16'($urandom), 16'h0000};
                    v = {{14{v[31]}}, 16'($urandom), 2'b00};
                end
            endcase
            send_const(v);
            acc = 32'h0;
            nw = 0;
            done = 1'b0;
            while (!done && nw < 3) begin
                get_word(w, ok);
                if (!ok) break;
                nw++;
                if (w[2:1] == 2'b10) acc = extend(w[18:3], w[2:1]);
                else acc = acc | extend(w[18:3], w[2:1]);
                done = w[0];
            end
            check($sformatf("oracle%0d_value", r), acc, v);
            check($sformatf("oracle%0d_words", r), 32'(nw), one_word_fits(v) ? 32'd1 : 32'd2);
            $display("txn oracle%0d value=%08h words=%0d rebuilt=%08h", r, v, nw, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
